seq_div_32x16: RTL and testbench



---
 rtl/seq_div_32x16.sv | 178 +++++++++++++++++
 tb/tb_seq_div_32x16.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_32x16.sv
// Sequential restoring divider: 32-bit dividend / 16-bit divisor, one quotient
// bit per clock, start/busy/done handshake, registered results and error flags.
module seq_div_32x16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [15:0] r_part;
    logic [15:0] r_shq;
    logic [15:0] r_divisor;
    logic [3:0]  r_cnt;
    logic        r_dbz_pend;
    logic        r_ovf_pend;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_quot;
    logic [15:0] r_rem;
    logic        r_dbz;
    logic        r_ovf;

    state_t      w_state_next;
    logic [15:0] w_part_next;
    logic [15:0] w_shq_next;
    logic [15:0] w_divisor_next;
    logic [3:0]  w_cnt_next;
    logic        w_dbz_pend_next;
    logic        w_ovf_pend_next;
    logic        w_busy_next;
    logic        w_done_next;
    logic [15:0] w_quot_next;
    logic [15:0] w_rem_next;
    logic        w_dbz_next;
    logic        w_ovf_next;

    logic [16:0] w_t;
    logic        w_ge;
    logic [15:0] w_sub;
    logic [15:0] w_part_step;
    logic [15:0] w_shq_step;

    // One restoring step; the 16-bit subtraction is exact because R < divisor
    // guarantees the true difference fits in 16 bits whenever T >= divisor.
    assign w_t         = {r_part, r_shq[15]};
    assign w_ge        = (w_t >= {1'b0, r_divisor});
    assign w_sub       = w_t[15:0] - r_divisor;
    assign w_part_step = w_ge ? w_sub : w_t[15:0];
    assign w_shq_step  = {r_shq[14:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_part     <= '0;
            r_shq      <= '0;
            r_divisor  <= '0;
            r_cnt      <= '0;
            r_dbz_pend <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_part     <= w_part_next;
            r_shq      <= w_shq_next;
            r_divisor  <= w_divisor_next;
            r_cnt      <= w_cnt_next;
            r_dbz_pend <= w_dbz_pend_next;
            r_ovf_pend <= w_ovf_pend_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_quot     <= w_quot_next;
            r_rem      <= w_rem_next;
            r_dbz      <= w_dbz_next;
            r_ovf      <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_part_next     = r_part;
        w_shq_next      = r_shq;
        w_divisor_next  = r_divisor;
        w_cnt_next      = r_cnt;
        w_dbz_pend_next = r_dbz_pend;
        w_ovf_pend_next = r_ovf_pend;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_quot_next     = r_quot;
        w_rem_next      = r_rem;
        w_dbz_next      = r_dbz;
        w_ovf_next      = r_ovf;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_divisor_next = divisor;
                    w_busy_next    = 1'b1;
                    w_cnt_next     = '0;
                    // Error results are staged in the working registers and only
                    // published on the following edge, together with done.
                    if (divisor == 16'd0) begin
                        w_part_next     = dividend[15:0];
                        w_shq_next      = 16'hFFFF;
                        w_dbz_pend_next = 1'b1;
                        w_ovf_pend_next = 1'b0;
                        w_state_next    = S_FINISH;
                    end else if (dividend[31:16] >= divisor) begin
                        w_part_next     = 16'hFFFF;
                        w_shq_next      = 16'hFFFF;
                        w_dbz_pend_next = 1'b0;
                        w_ovf_pend_next = 1'b1;
                        w_state_next    = S_FINISH;
                    end else begin
                        w_part_next     = dividend[31:16];
                        w_shq_next      = dividend[15:0];
                        w_dbz_pend_next = 1'b0;
                        w_ovf_pend_next = 1'b0;
                        w_state_next    = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_part_next = w_part_step;
                w_shq_next  = w_shq_step;
                w_cnt_next  = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_quot_next  = w_shq_step;
                    w_rem_next   = w_part_step;
                    w_dbz_next   = 1'b0;
                    w_ovf_next   = 1'b0;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            S_FINISH: begin
                w_quot_next  = r_shq;
                w_rem_next   = r_part;
                w_dbz_next   = r_dbz_pend;
                w_ovf_next   = r_ovf_pend;
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_div_32x16.sv
// Scoreboard bench for seq_div_32x16: stimulus pushes arithmetic expectations,
// a negedge monitor pops and compares whenever done is seen.
module tb_seq_div_32x16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    seq_div_32x16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer division with the documented error rules.
    function automatic exp_t model(input logic [31:0] n, input logic [15:0] d, input int now);
        exp_t e;
        longint unsigned qq;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (d == 16'd0) begin
            e.dbz = 1'b1;
            e.q   = 16'hFFFF;
            e.r   = n[15:0];
            e.cyc = now + 2;
        end else begin
            qq = longint'(n) / longint'(d);
            if (qq > 64'd65535) begin
                e.ovf = 1'b1;
                e.q   = 16'hFFFF;
                e.r   = 16'hFFFF;
                e.cyc = now + 2;
            end else begin
                e.q   = qq[15:0];
                e.r   = 16'(longint'(n) % longint'(d));
                e.cyc = now + 17;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                txn++;
                $display("txn %0d: q=%h r=%h dbz=%b ovf=%b cyc=%0d", txn, quotient, remainder,
                         div_by_zero, overflow, cyc);
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Leaves the caller on a negedge with busy low (i.e. the FSM is in IDLE).
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Called on a negedge while idle; returns 1 time unit after the accepting edge.
    task automatic issue_exp(input logic [31:0] n, input logic [15:0] d, input exp_t e);
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic issue(input logic [31:0] n, input logic [15:0] d);
        issue_exp(n, d, model(n, d, cyc));
    endtask

    initial begin
        exp_t e;
        logic [31:0] a, b, r;
        int n;

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst      = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases, issued back to back in each preceding done cycle.
        wait_idle(); issue(32'h0000_0064, 16'h0007);
        wait_idle(); issue(32'hFFFE_0001, 16'hFFFF);
        wait_idle(); issue(32'h0001_0000, 16'h0001);
        wait_idle(); issue(32'h1234_5678, 16'h0000);
        wait_idle(); issue(32'h0000_FFFF, 16'h0001);
        wait_idle(); issue(32'h0000_0000, 16'h0005);

        // Start pulses mid-run must be ignored.
        wait_idle(); issue(32'h0000_0064, 16'h0007);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; dividend = 32'h0001_0000; divisor = 16'h0000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; dividend = 32'h0000_0009; divisor = 16'h0003;
        @(posedge clk);
        #1 start = 1'b0;

        // Reset at iteration 8 abandons the division silently.
        wait_idle(); issue(32'h7FFF_1234, 16'h8001);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        wait_idle(); issue(32'h0000_0064, 16'h0007);

        // Round-trip against products a*b + r with r < b.
        for (int i = 0; i < 1000; i++) begin
            a = 32'($urandom_range(0, 65535));
            b = 32'($urandom_range(1, 65535));
            r = $urandom % b;
            e.q   = a[15:0];
            e.r   = r[15:0];
            e.dbz = 1'b0;
            e.ovf = 1'b0;
            wait_idle();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            e.cyc = cyc + 17;
            issue_exp(a * b + r, b[15:0], e);
        end

        // Unconstrained operands, biased toward the error paths.
        for (int i = 0; i < 60; i++) begin
            wait_idle();
            case ($urandom_range(0, 2))
                0: issue($urandom, 16'd0);
                1: issue($urandom, 16'($urandom_range(1, 255)));
                default: issue($urandom, 16'($urandom));
            endcase
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        n = checks;
        $display("TB_RESULT checks=%0d failures=%0d", n, failures);
        $finish;
    end

endmodule
